// File: rtl/readout_seq_pkg.sv
// Shared types and helpers for the frame readout sequencer: state encoding,
// ROI reset defaults, readout window length and the ROI validity rule.
package readout_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READ   = 2'd2,
        ST_COOL   = 2'd3
    } seq_state_t;

    localparam logic [5:0] ROI_ROW_START_DEF = 6'd0;
    localparam logic [5:0] ROI_ROW_END_DEF   = 6'd47;
    localparam logic [3:0] ROI_COL_START_DEF = 4'd0;
    localparam logic [3:0] ROI_COL_END_DEF   = 4'd15;

    function automatic int window_len(input int rows, input int ch_per_row, input int tail);
        return rows * ch_per_row + tail;
    endfunction

    // An all-zero request or an inverted axis is rejected.
    function automatic logic roi_valid(input logic [5:0] rs, input logic [5:0] re,
                                       input logic [3:0] cs, input logic [3:0] ce);
        return !((rs == 6'd0) && (re == 6'd0) && (cs == 4'd0) && (ce == 4'd0))
               && (rs <= re) && (cs <= ce);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that holds at 16'hFFFF instead of wrapping.
module sat_counter16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INC,
    output logic [15:0] COUNT
);

    logic [15:0] count_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count_reg <= 16'd0;
        end else if (INC && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign COUNT = count_reg;

endmodule

// File: rtl/readout_sequencer.sv
// Frame readout controller: settle gap, one readout window, cool-down, ROI updates between frames.
// Optional macro READOUT_SEQ_PENDING_EN adds a one-deep pending frame slot for early FRAME_READY pulses.
module readout_sequencer
    import readout_seq_pkg::*;
#(
    parameter int ROWS        = 48,
    parameter int CH_PER_ROW  = 50,
    parameter int TAIL        = 8,
    parameter int GAP_CYCLES  = 100,
    parameter int COOL_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FRAME_READY,
    input  logic        FIFO_PROG_FULL,
    input  logic        FRAME_END_FLAG,
    input  logic        ROI_UPDATE,
    input  logic [5:0]  ROI_ROW_START,
    input  logic [5:0]  ROI_ROW_END,
    input  logic [3:0]  ROI_COL_START,
    input  logic [3:0]  ROI_COL_END,
    output logic        MEM_RD_FLAG,
    output logic        SET_PARAM,
    output logic [5:0]  ROW_START,
    output logic [5:0]  ROW_END,
    output logic [3:0]  COL_START,
    output logic [3:0]  COL_END,
    output logic        ROI_REJECT,
    output logic        BUSY,
    output logic        TIMEOUT,
    output logic [15:0] FRAME_COUNT,
    output logic [15:0] DROP_COUNT,
    output logic [15:0] ERR_COUNT
);

    localparam int          WIN_CYCLES = window_len(ROWS, CH_PER_ROW, TAIL);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] WIN_LAST   = 16'(WIN_CYCLES - 1);
    localparam logic [15:0] COOL_LAST  = 16'(COOL_CYCLES - 1);

    seq_state_t  state_reg, state_next;
    logic [15:0] cyc_reg, cyc_next;
    logic        mem_rd_reg, busy_reg, timeout_reg, set_param_reg, roi_reject_reg;
    logic [5:0]  row_start_reg, row_end_reg;
    logic [3:0]  col_start_reg, col_end_reg;
    logic        roi_pend_reg;
    logic [5:0]  pend_row_start_reg, pend_row_end_reg;
    logic [3:0]  pend_col_start_reg, pend_col_end_reg;
    logic        fe_d_reg, end_seen_reg;
    logic        is_idle, fe_rise, win_last, frame_done;
    logic        start_req, accept, drop_inc, roi_apply, roi_ok;

    assign is_idle    = (state_reg == ST_IDLE);
    assign fe_rise    = FRAME_END_FLAG & ~fe_d_reg;
    assign win_last   = (state_reg == ST_READ) && (cyc_reg == WIN_LAST);
    // A frame-end edge arriving in the final READ cycle is folded in here.
    assign frame_done = end_seen_reg | fe_rise;
    assign accept     = start_req & ~FIFO_PROG_FULL;
    assign roi_ok     = roi_valid(pend_row_start_reg, pend_row_end_reg,
                                  pend_col_start_reg, pend_col_end_reg);
    // Applying on the COOL->IDLE edge makes SET_PARAM visible in the first IDLE cycle.
    assign roi_apply  = roi_pend_reg & (is_idle | (state_next == ST_IDLE));

`ifdef READOUT_SEQ_PENDING_EN
    logic frame_pend_reg, frame_pend_next;

    assign start_req       = is_idle & (FRAME_READY | frame_pend_reg);
    assign drop_inc        = (~is_idle & FRAME_READY & frame_pend_reg) | (start_req & FIFO_PROG_FULL);
    // In IDLE the stored frame is consumed; a coincident new pulse takes its place.
    assign frame_pend_next = is_idle ? (FRAME_READY & frame_pend_reg) : (frame_pend_reg | FRAME_READY);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_pend_reg <= 1'b0;
        end else begin
            frame_pend_reg <= frame_pend_next;
        end
    end
`else
    assign start_req = is_idle & FRAME_READY;
    assign drop_inc  = FRAME_READY & (~is_idle | FIFO_PROG_FULL);
`endif

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg + 16'd1;
        case (state_reg)
            ST_IDLE: begin
                cyc_next = 16'd0;
                if (accept) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cyc_reg == GAP_LAST) begin
                    state_next = ST_READ;
                    cyc_next   = 16'd0;
                end
            end
            ST_READ: begin
                if (cyc_reg == WIN_LAST) begin
                    state_next = ST_COOL;
                    cyc_next   = 16'd0;
                end
            end
            ST_COOL: begin
                if (cyc_reg == COOL_LAST) begin
                    state_next = ST_IDLE;
                    cyc_next   = 16'd0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cyc_next   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg          <= ST_IDLE;
            cyc_reg            <= 16'd0;
            mem_rd_reg         <= 1'b0;
            busy_reg           <= 1'b0;
            timeout_reg        <= 1'b0;
            set_param_reg      <= 1'b0;
            roi_reject_reg     <= 1'b0;
            row_start_reg      <= ROI_ROW_START_DEF;
            row_end_reg        <= ROI_ROW_END_DEF;
            col_start_reg      <= ROI_COL_START_DEF;
            col_end_reg        <= ROI_COL_END_DEF;
            roi_pend_reg       <= 1'b0;
            pend_row_start_reg <= 6'd0;
            pend_row_end_reg   <= 6'd0;
            pend_col_start_reg <= 4'd0;
            pend_col_end_reg   <= 4'd0;
            fe_d_reg           <= 1'b0;
            end_seen_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cyc_reg     <= cyc_next;
            mem_rd_reg  <= (state_next == ST_READ);
            busy_reg    <= (state_next != ST_IDLE);
            timeout_reg <= win_last & ~frame_done;
            fe_d_reg    <= FRAME_END_FLAG;

            if (state_reg != ST_READ) begin
                end_seen_reg <= 1'b0;
            end else if (fe_rise) begin
                end_seen_reg <= 1'b1;
            end

            if (ROI_UPDATE) begin
                roi_pend_reg       <= 1'b1;
                pend_row_start_reg <= ROI_ROW_START;
                pend_row_end_reg   <= ROI_ROW_END;
                pend_col_start_reg <= ROI_COL_START;
                pend_col_end_reg   <= ROI_COL_END;
            end else if (roi_apply) begin
                roi_pend_reg <= 1'b0;
            end

            set_param_reg  <= roi_apply & roi_ok;
            roi_reject_reg <= roi_apply & ~roi_ok;
            if (roi_apply && roi_ok) begin
                row_start_reg <= pend_row_start_reg;
                row_end_reg   <= pend_row_end_reg;
                col_start_reg <= pend_col_start_reg;
                col_end_reg   <= pend_col_end_reg;
            end
        end
    end

    logic [2:0]  cnt_inc;
    logic [15:0] cnt_val [3];

    assign cnt_inc = {drop_inc, win_last & ~frame_done, win_last & frame_done};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            sat_counter16 u_cnt (
                .CLK   (CLK),
                .RST   (RST),
                .INC   (cnt_inc[gi]),
                .COUNT (cnt_val[gi])
            );
        end
    endgenerate

    assign FRAME_COUNT = cnt_val[0];
    assign ERR_COUNT   = cnt_val[1];
    assign DROP_COUNT  = cnt_val[2];
    assign MEM_RD_FLAG = mem_rd_reg;
    assign BUSY        = busy_reg;
    assign TIMEOUT     = timeout_reg;
    assign SET_PARAM   = set_param_reg;
    assign ROI_REJECT  = roi_reject_reg;
    assign ROW_START   = row_start_reg;
    assign ROW_END     = row_end_reg;
    assign COL_START   = col_start_reg;
    assign COL_END     = col_end_reg;

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer; expected timing is derived arithmetically from
// gap/window/cool lengths, counters and ROI outputs from a small model (READOUT_SEQ_PENDING_EN aware).
`timescale 1ns/1ps
module tb_readout_sequencer;

    localparam int ROWS = 2;
    localparam int CH   = 50;
    localparam int TAIL = 8;
    localparam int GAP  = 4;
    localparam int COOL = 4;
    localparam int WIN  = ROWS * CH + TAIL;
    localparam int MAXC = 400;

    typedef bit hist_t [MAXC];

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FRAME_READY = 1'b0, FIFO_PROG_FULL = 1'b0, FRAME_END_FLAG = 1'b0, ROI_UPDATE = 1'b0;
    logic [5:0]  ROI_ROW_START = 6'd0, ROI_ROW_END = 6'd0;
    logic [3:0]  ROI_COL_START = 4'd0, ROI_COL_END = 4'd0;
    logic        MEM_RD_FLAG, SET_PARAM, ROI_REJECT, BUSY, TIMEOUT;
    logic [5:0]  ROW_START, ROW_END;
    logic [3:0]  COL_START, COL_END;
    logic [15:0] FRAME_COUNT, DROP_COUNT, ERR_COUNT;

    readout_sequencer #(
        .ROWS(ROWS), .CH_PER_ROW(CH), .TAIL(TAIL), .GAP_CYCLES(GAP), .COOL_CYCLES(COOL)
    ) dut (
        .CLK(CLK), .RST(RST), .FRAME_READY(FRAME_READY), .FIFO_PROG_FULL(FIFO_PROG_FULL),
        .FRAME_END_FLAG(FRAME_END_FLAG), .ROI_UPDATE(ROI_UPDATE),
        .ROI_ROW_START(ROI_ROW_START), .ROI_ROW_END(ROI_ROW_END),
        .ROI_COL_START(ROI_COL_START), .ROI_COL_END(ROI_COL_END),
        .MEM_RD_FLAG(MEM_RD_FLAG), .SET_PARAM(SET_PARAM),
        .ROW_START(ROW_START), .ROW_END(ROW_END), .COL_START(COL_START), .COL_END(COL_END),
        .ROI_REJECT(ROI_REJECT), .BUSY(BUSY), .TIMEOUT(TIMEOUT),
        .FRAME_COUNT(FRAME_COUNT), .DROP_COUNT(DROP_COUNT), .ERR_COUNT(ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frames = 0, exp_drops = 0, exp_errs = 0;
    logic [5:0] exp_rs = 6'd0, exp_re = 6'd47;
    logic [3:0] exp_cs = 4'd0, exp_ce = 4'd15;

    hist_t fr_s, fe_s, roi_s, ff_s;
    hist_t mrd_h, busy_h, to_h, sp_h, rj_h;

    function automatic int cnt(input hist_t a, input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(a[i]);
        return c;
    endfunction

    function automatic int first1(input hist_t a, input int from);
        for (int i = from; i < MAXC; i++) if (a[i]) return i;
        return -1;
    endfunction

    function automatic int first0(input hist_t a, input int from);
        for (int i = from; i < MAXC; i++) if (!a[i]) return i;
        return -1;
    endfunction

    function automatic bit roi_ok(input logic [5:0] rs, input logic [5:0] re,
                                  input logic [3:0] cs, input logic [3:0] ce);
        if (rs == 0 && re == 0 && cs == 0 && ce == 0) return 1'b0;
        return (rs <= re) && (cs <= ce);
    endfunction

    task automatic clear_sched();
        for (int i = 0; i < MAXC; i++) begin
            fr_s[i] = 0; fe_s[i] = 0; roi_s[i] = 0; ff_s[i] = 0;
            mrd_h[i] = 0; busy_h[i] = 0; to_h[i] = 0; sp_h[i] = 0; rj_h[i] = 0;
        end
    endtask

    // Edge k samples the inputs scheduled at index k; history index k holds outputs just after edge k.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            FRAME_READY    = fr_s[k];
            FRAME_END_FLAG = fe_s[k];
            ROI_UPDATE     = roi_s[k];
            FIFO_PROG_FULL = ff_s[k];
            @(posedge CLK); #1;
            mrd_h[k] = MEM_RD_FLAG; busy_h[k] = BUSY; to_h[k] = TIMEOUT;
            sp_h[k] = SET_PARAM; rj_h[k] = ROI_REJECT;
        end
        FRAME_READY = 0; FRAME_END_FLAG = 0; ROI_UPDATE = 0; FIFO_PROG_FULL = 0;
        @(posedge CLK); #1;
    endtask

    task automatic set_roi(input logic [5:0] rs, input logic [5:0] re, input logic [3:0] cs, input logic [3:0] ce);
        ROI_ROW_START = rs; ROI_ROW_END = re; ROI_COL_START = cs; ROI_COL_END = ce;
    endtask

    task automatic rand_valid_roi();
        logic [5:0] rs, re;
        logic [3:0] cs, ce;
        rs = 6'($urandom_range(0, 47));
        re = 6'($urandom_range(int'(rs), 63));
        cs = 4'($urandom_range(0, 15));
        ce = 4'($urandom_range(int'(cs), 15));
        if (rs == 0 && re == 0 && cs == 0 && ce == 0) re = 6'd1;
        set_roi(rs, re, cs, ce);
    endtask

    task automatic take_roi_model();
        if (roi_ok(ROI_ROW_START, ROI_ROW_END, ROI_COL_START, ROI_COL_END)) begin
            exp_rs = ROI_ROW_START; exp_re = ROI_ROW_END; exp_cs = ROI_COL_START; exp_ce = ROI_COL_END;
        end
    endtask

    task automatic chk_counters(input string tag);
        n_cmp++;
        if ({FRAME_COUNT, ERR_COUNT, DROP_COUNT} !== {16'(exp_frames), 16'(exp_errs), 16'(exp_drops)}) begin
            n_bad++;
            $display("FAIL %s_counters: got frame/err/drop %0d/%0d/%0d expected %0d/%0d/%0d", tag,
                     FRAME_COUNT, ERR_COUNT, DROP_COUNT, exp_frames, exp_errs, exp_drops);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        n_cmp++;
        if ({MEM_RD_FLAG, SET_PARAM, ROI_REJECT, BUSY, TIMEOUT} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000", {MEM_RD_FLAG, SET_PARAM, ROI_REJECT, BUSY, TIMEOUT});
        end
        n_cmp++;
        if ({ROW_START, ROW_END, COL_START, COL_END} !== {6'd0, 6'd47, 4'd0, 4'd15}) begin
            n_bad++;
            $display("FAIL reset_roi: got %0d/%0d/%0d/%0d expected 0/47/0/15", ROW_START, ROW_END, COL_START, COL_END);
        end
        chk_counters("reset");
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_cmp++;
        if ({MEM_RD_FLAG, BUSY} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_release_idle: got rd/busy %b expected 00", {MEM_RD_FLAG, BUSY});
        end
        $display("reset: checked reset values");
    endtask

    task automatic test_invalid_roi();
        logic [19:0] cases [9];
        bit ok;
        cases[0] = {6'd30, 6'd10, 4'd2, 4'd9};
        cases[1] = {6'd0, 6'd0, 4'd0, 4'd0};
        cases[2] = {6'd3, 6'd8, 4'd9, 4'd4};
        cases[3] = {6'd7, 6'd7, 4'd3, 4'd3};
        cases[4] = {6'd0, 6'd0, 4'd0, 4'd1};
        for (int i = 5; i < 9; i++) cases[i] = 20'($urandom);
        for (int i = 0; i < 9; i++) begin
            set_roi(cases[i][19:14], cases[i][13:8], cases[i][7:4], cases[i][3:0]);
            ok = roi_ok(ROI_ROW_START, ROI_ROW_END, ROI_COL_START, ROI_COL_END);
            take_roi_model();
            clear_sched();
            roi_s[0] = 1;
            run(5);
            n_cmp++;
            if (cnt(rj_h, 0, 4) != int'(!ok) || cnt(sp_h, 0, 4) != int'(ok)) begin
                n_bad++;
                $display("FAIL roi_case%0d_strobes: got reject/set %0d/%0d expected %0d/%0d", i,
                         cnt(rj_h, 0, 4), cnt(sp_h, 0, 4), int'(!ok), int'(ok));
            end
            n_cmp++;
            if ({ROW_START, ROW_END, COL_START, COL_END} !== {exp_rs, exp_re, exp_cs, exp_ce}) begin
                n_bad++;
                $display("FAIL roi_case%0d_outputs: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                         ROW_START, ROW_END, COL_START, COL_END, exp_rs, exp_re, exp_cs, exp_ce);
            end
            $display("roi %0d: req %0d/%0d/%0d/%0d valid=%0d", i, cases[i][19:14], cases[i][13:8],
                     cases[i][7:4], cases[i][3:0], ok);
        end
    endtask

    task automatic test_basic_frame();
        int fek, n;
        n = GAP + WIN + COOL + 3;
        for (int r = 0; r < 3; r++) begin
            fek = (r == 0) ? 90 : (r == 1) ? GAP + WIN : int'($urandom_range(GAP + 1, GAP + WIN - 1));
            clear_sched();
            fr_s[0] = 1;
            for (int k = fek; k < n; k++) fe_s[k] = 1;
            if (r == 2) for (int k = 2; k < n; k++) ff_s[k] = 1;
            run(n);
            exp_frames++;
            n_cmp++;
            if (first1(mrd_h, 0) != GAP) begin
                n_bad++;
                $display("FAIL basic%0d_rise: got %0d expected %0d", r, first1(mrd_h, 0), GAP);
            end
            n_cmp++;
            if (cnt(mrd_h, GAP, GAP + WIN - 1) != WIN || cnt(mrd_h, 0, n - 1) != WIN) begin
                n_bad++;
                $display("FAIL basic%0d_window: got in-window %0d total %0d expected %0d", r,
                         cnt(mrd_h, GAP, GAP + WIN - 1), cnt(mrd_h, 0, n - 1), WIN);
            end
            n_cmp++;
            if (busy_h[0] !== 1'b1 || first0(busy_h, 0) != GAP + WIN + COOL) begin
                n_bad++;
                $display("FAIL basic%0d_busy: got first busy %0d, idle at %0d expected 1, %0d", r,
                         busy_h[0], first0(busy_h, 0), GAP + WIN + COOL);
            end
            n_cmp++;
            if (cnt(to_h, 0, n - 1) != 0) begin
                n_bad++;
                $display("FAIL basic%0d_timeout: got %0d pulses expected 0", r, cnt(to_h, 0, n - 1));
            end
            chk_counters("basic");
            $display("frame basic %0d: fe_k=%0d rise=%0d len=%0d", r, fek, first1(mrd_h, 0), cnt(mrd_h, 0, n - 1));
        end
    endtask

    task automatic test_missing_end();
        int n;
        n = GAP + WIN + COOL + 3;
        for (int r = 0; r < 2; r++) begin
            clear_sched();
            fr_s[0] = 1;
            if (r == 1) for (int k = GAP + WIN + 1; k < n; k++) fe_s[k] = 1;
            run(n);
            exp_errs++;
            n_cmp++;
            if (cnt(to_h, 0, n - 1) != 1 || to_h[GAP + WIN] !== 1'b1) begin
                n_bad++;
                $display("FAIL noend%0d_timeout: got %0d pulses first at %0d expected 1 at %0d", r,
                         cnt(to_h, 0, n - 1), first1(to_h, 0), GAP + WIN);
            end
            n_cmp++;
            if (cnt(mrd_h, 0, n - 1) != WIN) begin
                n_bad++;
                $display("FAIL noend%0d_window: got %0d expected %0d", r, cnt(mrd_h, 0, n - 1), WIN);
            end
            chk_counters("noend");
            $display("frame noend %0d: timeout at %0d", r, first1(to_h, 0));
        end
    endtask

    task automatic test_backpressure();
        int k1, k2, k3;
        k1 = int'($urandom_range(1, 8));
        k2 = k1 + int'($urandom_range(1, 8));
        k3 = k2 + int'($urandom_range(1, 8));
        clear_sched();
        for (int k = 0; k < 40; k++) ff_s[k] = 1;
        fr_s[k1] = 1; fr_s[k2] = 1; fr_s[k3] = 1;
        run(40);
        exp_drops += 3;
        n_cmp++;
        if (cnt(mrd_h, 0, 39) != 0 || cnt(busy_h, 0, 39) != 0) begin
            n_bad++;
            $display("FAIL backpressure_idle: got rd %0d busy %0d cycles expected 0/0",
                     cnt(mrd_h, 0, 39), cnt(busy_h, 0, 39));
        end
        chk_counters("backpressure");
        $display("backpressure: pulses at %0d %0d %0d, drops=%0d", k1, k2, k3, DROP_COUNT);
    endtask

    task automatic test_roi_during_read();
        int n, rk, both;
        n = GAP + WIN + COOL + 4;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) set_roi(6'd5, 6'd20, 4'd2, 4'd9);
            else rand_valid_roi();
            take_roi_model();
            rk = int'($urandom_range(GAP + 1, GAP + WIN));
            clear_sched();
            fr_s[0] = 1;
            roi_s[rk] = 1;
            for (int k = 50; k < n; k++) fe_s[k] = 1;
            run(n);
            exp_frames++;
            both = 0;
            for (int k = 0; k < n; k++) both += int'(sp_h[k] & mrd_h[k]);
            n_cmp++;
            if (cnt(sp_h, 0, n - 1) != 1 || sp_h[GAP + WIN + COOL] !== 1'b1) begin
                n_bad++;
                $display("FAIL roiread%0d_setparam: got %0d pulses first at %0d expected 1 at %0d", r,
                         cnt(sp_h, 0, n - 1), first1(sp_h, 0), GAP + WIN + COOL);
            end
            n_cmp++;
            if (both != 0) begin
                n_bad++;
                $display("FAIL roiread%0d_overlap: got %0d cycles of SET_PARAM with MEM_RD_FLAG expected 0", r, both);
            end
            n_cmp++;
            if ({ROW_START, ROW_END, COL_START, COL_END} !== {exp_rs, exp_re, exp_cs, exp_ce}) begin
                n_bad++;
                $display("FAIL roiread%0d_outputs: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", r,
                         ROW_START, ROW_END, COL_START, COL_END, exp_rs, exp_re, exp_cs, exp_ce);
            end
            chk_counters("roiread");
            $display("roi during read %0d: sent at %0d, applied at %0d", r, rk, first1(sp_h, 0));
        end
    endtask

    task automatic test_simultaneous();
        int n;
        n = GAP + WIN + COOL + 5;
        // ROI pending in IDLE, frame arriving one cycle later.
        rand_valid_roi();
        take_roi_model();
        clear_sched();
        roi_s[0] = 1;
        fr_s[1] = 1;
        for (int k = 60; k < n; k++) fe_s[k] = 1;
        run(n);
        exp_frames++;
        n_cmp++;
        if (first1(mrd_h, 0) != 1 + GAP) begin
            n_bad++;
            $display("FAIL simul_a_rise: got %0d expected %0d", first1(mrd_h, 0), 1 + GAP);
        end
        n_cmp++;
        if (cnt(sp_h, 0, n - 1) != 1 || first1(sp_h, 0) < 0 || first1(mrd_h, 0) - first1(sp_h, 0) < GAP) begin
            n_bad++;
            $display("FAIL simul_a_setparam: got %0d pulses at %0d, rise at %0d expected 1 pulse >= %0d before rise",
                     cnt(sp_h, 0, n - 1), first1(sp_h, 0), first1(mrd_h, 0), GAP);
        end
        $display("simultaneous a: set_param at %0d rise at %0d", first1(sp_h, 0), first1(mrd_h, 0));
        // ROI and frame in the very same cycle.
        rand_valid_roi();
        take_roi_model();
        clear_sched();
        roi_s[0] = 1;
        fr_s[0] = 1;
        for (int k = 60; k < n; k++) fe_s[k] = 1;
        run(n);
        exp_frames++;
        n_cmp++;
        if (first1(mrd_h, 0) != GAP || cnt(mrd_h, 0, n - 1) != WIN) begin
            n_bad++;
            $display("FAIL simul_b_window: got rise %0d len %0d expected %0d/%0d",
                     first1(mrd_h, 0), cnt(mrd_h, 0, n - 1), GAP, WIN);
        end
        n_cmp++;
        if (cnt(sp_h, 0, n - 1) != 1 || mrd_h[first1(sp_h, 0) < 0 ? 0 : first1(sp_h, 0)]) begin
            n_bad++;
            $display("FAIL simul_b_setparam: got %0d pulses at %0d expected 1 outside window",
                     cnt(sp_h, 0, n - 1), first1(sp_h, 0));
        end
        n_cmp++;
        if ({ROW_START, ROW_END, COL_START, COL_END} !== {exp_rs, exp_re, exp_cs, exp_ce}) begin
            n_bad++;
            $display("FAIL simul_b_outputs: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                     ROW_START, ROW_END, COL_START, COL_END, exp_rs, exp_re, exp_cs, exp_ce);
        end
        chk_counters("simul");
        $display("simultaneous b: set_param at %0d rise at %0d", first1(sp_h, 0), first1(mrd_h, 0));
    endtask

    task automatic test_back_to_back();
        int s2, n, idle_k;
        idle_k = GAP + WIN + COOL;
        s2 = idle_k + 1 + GAP;
        n = s2 + WIN + COOL + 4;
        clear_sched();
        fr_s[0] = 1;
        fr_s[GAP + 10] = 1;
        for (int k = 30; k < GAP + WIN + 5; k++) fe_s[k] = 1;
        for (int k = s2 + 20; k < n; k++) fe_s[k] = 1;
        run(n);
`ifdef READOUT_SEQ_PENDING_EN
        exp_frames += 2;
        n_cmp++;
        if (cnt(mrd_h, 0, n - 1) != 2 * WIN || first1(mrd_h, GAP + WIN) != s2) begin
            n_bad++;
            $display("FAIL b2b_second_window: got total %0d second rise %0d expected %0d/%0d",
                     cnt(mrd_h, 0, n - 1), first1(mrd_h, GAP + WIN), 2 * WIN, s2);
        end
        n_cmp++;
        if (first0(busy_h, 0) != idle_k || busy_h[idle_k + 1] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_busy_gap: got idle at %0d busy after %0d expected idle only at %0d",
                     first0(busy_h, 0), busy_h[idle_k + 1], idle_k);
        end
`else
        exp_frames += 1;
        exp_drops += 1;
        n_cmp++;
        if (cnt(mrd_h, 0, n - 1) != WIN || first1(mrd_h, 0) != GAP) begin
            n_bad++;
            $display("FAIL b2b_single_window: got total %0d rise %0d expected %0d/%0d",
                     cnt(mrd_h, 0, n - 1), first1(mrd_h, 0), WIN, GAP);
        end
`endif
        chk_counters("b2b");
        $display("back to back: windows=%0d cycles high=%0d", cnt(mrd_h, 0, n - 1) / WIN, cnt(mrd_h, 0, n - 1));
    endtask

    task automatic test_reset_mid_read();
        clear_sched();
        fr_s[0] = 1;
        for (int k = 0; k < GAP + 10; k++) begin
            FRAME_READY = fr_s[k];
            @(posedge CLK); #1;
        end
        FRAME_READY = 1'b0;
        n_cmp++;
        if (MEM_RD_FLAG !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_pre: got MEM_RD_FLAG %b expected 1", MEM_RD_FLAG);
        end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({MEM_RD_FLAG, BUSY} !== 2'b00) begin
            n_bad++;
            $display("FAIL rstmid_async: got rd/busy %b expected 00 before next edge", {MEM_RD_FLAG, BUSY});
        end
        exp_frames = 0; exp_errs = 0; exp_drops = 0;
        exp_rs = 6'd0; exp_re = 6'd47; exp_cs = 4'd0; exp_ce = 4'd15;
        chk_counters("rstmid");
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if ({ROW_START, ROW_END, COL_START, COL_END, MEM_RD_FLAG} !== {exp_rs, exp_re, exp_cs, exp_ce, 1'b0}) begin
            n_bad++;
            $display("FAIL rstmid_roi: got %0d/%0d/%0d/%0d rd %b expected 0/47/0/15 rd 0",
                     ROW_START, ROW_END, COL_START, COL_END, MEM_RD_FLAG);
        end
        $display("reset mid read: window aborted");
    endtask

    initial begin
        clear_sched();
        test_reset();
        test_invalid_roi();
        test_basic_frame();
        test_missing_end();
        test_backpressure();
        test_roi_during_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Frame-level controller for the pixel readout datapath. It decides when a written frame is read out. After a frame-ready pulse from the front-end write side, it waits a settle gap, then drives `MEM_RD_FLAG` for one full readout window. It applies region-of-interest (ROI) updates only between frames, sheds frames when the downstream FIFO is near full, and checks that the row/column data selector reports frame completion inside each window.

## Interface
Parameters:
- `ROWS`, default 48: memory rows (addresses) per frame.
- `CH_PER_ROW`, default 50: selector channel slots per row.
- `TAIL`, default 8: extra `READ` cycles covering the selector pipeline.
- `GAP_CYCLES`, default 100: settle delay after `FRAME_READY` (the write-finish margin).
- `COOL_CYCLES`, default 4: minimum `MEM_RD_FLAG` low time between frames. Must be ≥ 2.

Ports (reset is asynchronous, active-high):
- `CLK` in 1: system clock, 100 MHz.
- `RST` in 1: async active-high reset.
- `FRAME_READY` in 1: one-cycle pulse; frame memories are written.
- `FIFO_PROG_FULL` in 1: downstream FIFO cannot accept a frame.
- `FRAME_END_FLAG` in 1: selector frame-end level; only its rising edge is used.
- `ROI_UPDATE` in 1: one-cycle pulse requesting a new ROI.
- `ROI_ROW_START`, `ROI_ROW_END` in 6: requested row bounds.
- `ROI_COL_START`, `ROI_COL_END` in 4: requested column bounds.
- `MEM_RD_FLAG` out 1: readout window to the selector.
- `SET_PARAM` out 1: one-cycle parameter load strobe.
- `ROW_START`, `ROW_END` out 6: applied row bounds.
- `COL_START`, `COL_END` out 4: applied column bounds.
- `ROI_REJECT` out 1: one-cycle pulse when a requested ROI is invalid.
- `BUSY` out 1: high in any state other than `IDLE`.
- `TIMEOUT` out 1: one-cycle pulse when a window ends without a frame end.
- `FRAME_COUNT`, `DROP_COUNT`, `ERR_COUNT` out 16: saturating counters.

## Operation
- Reset values:
  - All outputs are 0, except `ROW_END` = 47 and `COL_END` = 15.
  - State is `IDLE`; the pending ROI and pending frame slots are cleared.
- States: `IDLE`, `SETTLE`, `READ`, `COOL`.
- `IDLE`:
  - On `FRAME_READY` with `FIFO_PROG_FULL` = 0: go to `SETTLE` and clear the gap counter.
  - On `FRAME_READY` with `FIFO_PROG_FULL` = 1: stay in `IDLE` and increment `DROP_COUNT`.
- `SETTLE`: counts `GAP_CYCLES`, then goes to `READ`.
- `READ`:
  - `MEM_RD_FLAG` = 1 for exactly `ROWS*CH_PER_ROW+TAIL` cycles, then go to `COOL`.
  - A `FRAME_END_FLAG` rising edge sets `end_seen`.
  - On exit:
    - If `end_seen` = 1, increment `FRAME_COUNT`.
    - Otherwise, pulse `TIMEOUT` and increment `ERR_COUNT`.
- `COOL`: `MEM_RD_FLAG` = 0 for `COOL_CYCLES` cycles, then return to `IDLE`.
- ROI handling:
  - `ROI_UPDATE` is captured into a one-deep pending slot in any state. A newer request overwrites an unapplied one.
  - The pending ROI is applied only in `IDLE`.
  - A request is invalid if all four fields are 0, or start > end on either axis.
  - Valid request: registers the `ROW_*`/`COL_*` outputs and pulses `SET_PARAM` in the same cycle.
  - Invalid request: pulses `ROI_REJECT`; outputs are unchanged.
- Simultaneous events:
  - Applying a pending ROI and accepting `FRAME_READY` in the same `IDLE` cycle is allowed. `SET_PARAM` precedes `MEM_RD_FLAG` by ≥ `GAP_CYCLES`.
  - `FRAME_READY` and `ROI_UPDATE` arriving together are both honoured.
- Counters saturate at 16'hFFFF and never wrap.
- A reset during any state returns to the reset values immediately. `MEM_RD_FLAG` falls asynchronously.

## Timing
- `FRAME_READY` sampled at edge t:
  - `BUSY` = 1 from t+1.
  - `MEM_RD_FLAG` = 1 from t+1+`GAP_CYCLES`.
- `MEM_RD_FLAG` is glitch-free and registered. Its rise is one clean edge, so the selector sees exactly one restart pulse.
- `SET_PARAM` lasts exactly one cycle and never occurs while `MEM_RD_FLAG` = 1.
- `FRAME_END_FLAG` edge detection takes one register stage. An edge in the last `READ` cycle still counts.
- `FIFO_PROG_FULL` is sampled only at frame acceptance; a later assertion does not abort a window.

## Configuration
- `READOUT_SEQ_PENDING_EN` defined:
  - A `FRAME_READY` arriving in `SETTLE`, `READ` or `COOL` is stored in a one-deep pending frame slot.
  - On return to `IDLE`, the pending frame is started (subject to the `FIFO_PROG_FULL` check).
  - A second arrival while the slot is full increments `DROP_COUNT`.
- `READOUT_SEQ_PENDING_EN` undefined: every `FRAME_READY` outside `IDLE` increments `DROP_COUNT`.

## Structure
- Package `readout_seq_pkg` holds:
  - The state enum.
  - ROI reset defaults (row 0/47, col 0/15).
  - The window length function `ROWS*CH_PER_ROW+TAIL`.
- Sub-module `sat_counter16`:
  - Ports: `CLK`, `RST`, `INC`, `COUNT`.
  - Instantiated three times.

## Test plan
- Basic frame, using `GAP_CYCLES`=4, `ROWS`=2, `CH_PER_ROW`=50, `TAIL`=8:
  - `FRAME_READY` at t=10, selector model raises `FRAME_END_FLAG` at t=100.
  - Required: `MEM_RD_FLAG` high for 108 cycles starting t=15; `FRAME_COUNT`=1; no `TIMEOUT`.
- Missing frame end:
  - No `FRAME_END_FLAG` edge during the window.
  - Required: `TIMEOUT` pulses once at window end; `ERR_COUNT`=1; `FRAME_COUNT`=0.
- Backpressure:
  - `FIFO_PROG_FULL`=1 and 3 `FRAME_READY` pulses in `IDLE`.
  - Required: `DROP_COUNT`=3; `MEM_RD_FLAG` never rises.
- ROI during readout:
  - `ROI_UPDATE` with rows 5/20, cols 2/9 sent during `READ`.
  - Required: `SET_PARAM` only in the first `IDLE` cycle after `COOL`; outputs become 5/20/2/9.
- Invalid ROI:
  - `ROI_UPDATE` with rows 30/10.
  - Required: `ROI_REJECT` pulses; outputs keep 0/47/0/15.
- Back-to-back frames and reset:
  - A second `FRAME_READY` arrives in `READ`.
    - With `READOUT_SEQ_PENDING_EN`: a second window starts 1+`GAP_CYCLES` after `IDLE` re-entry.
    - Without it: `DROP_COUNT`=1.
  - `RST` asserted mid-`READ`: `MEM_RD_FLAG` drops without waiting for a clock edge; all counters return to 0.
